lock_key_loader: RTL and testbench

Sequencer that loads the activation key for a key-controlled MUX-locked netlist from a serial source and drives the locked core's key inputs D_0..D_{KEY_W-1}. It sits between the on-die key store and the locked combinational core. Keys are committed to the core only after a complete and optionally parity-checked load. Repeated bad loads escalate to a lockout that only reset clears.

---
 rtl/lock_ctrl_pkg.sv | 24 ++
 rtl/key_shift_reg.sv | 40 ++++
 rtl/lock_key_loader.sv | 164 ++++++++++++++++
 tb/tb_lock_key_loader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lock_ctrl_pkg.sv
// Shared types and constants for the key loader of the MUX-locked core.
// Optional feature macro used by the loader: KEY_PARITY_CHK_EN.
package lock_ctrl_pkg;

  // Loader sequencing states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_ARMED   = 3'd3,
    ST_LOCKOUT = 3'd4
  } lock_state_e;

  // Default key width (two select bits per key MUX) and failure threshold
  localparam int KEY_W_DEF    = 12;
  localparam int MAX_FAIL_DEF = 3;
  localparam int MUX_SEL_W    = 2;

  // Even parity across a key (zero-extended to 64 bits) plus its parity bit
  function automatic logic even_parity_ok(input logic [63:0] vec, input logic pbit);
    return (((^vec) ^ pbit) == 1'b0);
  endfunction

endpackage

// File: rtl/key_shift_reg.sv
// Shadow register and bit counter for the serial key load.
// Bits arrive LSB first; bit n lands in data[n]. Bits beyond KEY_W
// (the optional parity bit) are counted but not stored.
module key_shift_reg #(
  parameter int KEY_W    = 12,
  parameter int LOAD_LEN = 12,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             sdata,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic [KEY_W-1:0] data
);

  // The final bit of the load is being accepted this cycle
  assign done = shift_en && (count == CNT_W'(LOAD_LEN - 1));

  // Shadow capture and bit counting; clear has priority over shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      count <= '0;
    end else if (clear) begin
      data  <= '0;
      count <= '0;
    end else if (shift_en && (count != CNT_W'(LOAD_LEN))) begin
      for (int i = 0; i < KEY_W; i++) begin
        if (count == CNT_W'(i)) begin
          data[i] <= sdata;
        end
      end
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lock_key_loader.sv
// Loads the activation key for the MUX-locked core from a serial source and
// commits it to the core's key inputs only after a complete load.
// Optional parity checking with fail escalation: define KEY_PARITY_CHK_EN.
module lock_key_loader
  import lock_ctrl_pkg::*;
#(
  parameter int KEY_W    = KEY_W_DEF,
  parameter int MAX_FAIL = MAX_FAIL_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            key_sdata,
  input  logic                            key_svalid,
  output logic                            key_sready,
  output logic [KEY_W-1:0]                key_out,
  output logic                            key_valid,
  output logic                            busy,
  output logic                            fail,
  output logic                            lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int FC_W = $clog2(MAX_FAIL + 1);

`ifdef KEY_PARITY_CHK_EN
  localparam int LOAD_LEN = KEY_W + 1;
  localparam bit PAR_EN   = 1'b1;
`else
  localparam int LOAD_LEN = KEY_W;
  localparam bit PAR_EN   = 1'b0;
`endif

  localparam int CNT_W = $clog2(LOAD_LEN + 1);

  lock_state_e       state_r;
  logic [KEY_W-1:0]  key_out_r;
  logic              key_valid_r;
  logic              fail_r;
  logic              lockout_r;
  logic [FC_W-1:0]   fail_cnt_r;
  logic              parity_bit_r;

  logic              shift_en_s;
  logic              clear_s;
  logic [CNT_W-1:0]  count_s;
  logic              done_s;
  logic [KEY_W-1:0]  shadow_s;
  logic              check_pass_s;
  logic [FC_W-1:0]   fail_cnt_inc_s;

  key_shift_reg #(
    .KEY_W    (KEY_W),
    .LOAD_LEN (LOAD_LEN),
    .CNT_W    (CNT_W)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en_s),
    .clear    (clear_s),
    .sdata    (key_sdata),
    .count    (count_s),
    .done     (done_s),
    .data     (shadow_s)
  );

  // Shift-register control decoded from state and request inputs
  always_comb begin
    shift_en_s = 1'b0;
    clear_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_ARMED: clear_s    = start;
      ST_LOAD:           shift_en_s = key_svalid;
      default: begin
        shift_en_s = 1'b0;
        clear_s    = 1'b0;
      end
    endcase
  end

  // Check verdict and saturating increment of the failure count
  always_comb begin
    if (PAR_EN) begin
      check_pass_s = even_parity_ok(64'(shadow_s), parity_bit_r);
    end else begin
      check_pass_s = 1'b1;
    end
    if (fail_cnt_r == FC_W'(MAX_FAIL)) begin
      fail_cnt_inc_s = fail_cnt_r;
    end else begin
      fail_cnt_inc_s = fail_cnt_r + FC_W'(1);
    end
  end

  // Sequencer with registered outputs; key_out only ever takes 0 or a full key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      key_out_r    <= '0;
      key_valid_r  <= 1'b0;
      fail_r       <= 1'b0;
      lockout_r    <= 1'b0;
      fail_cnt_r   <= '0;
      parity_bit_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_ARMED: begin
          if (start) begin
            state_r      <= ST_LOAD;
            key_out_r    <= '0;
            key_valid_r  <= 1'b0;
            fail_r       <= 1'b0;
            parity_bit_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          // The bit after the last key bit is the parity bit
          if (shift_en_s && (count_s == CNT_W'(KEY_W))) begin
            parity_bit_r <= key_sdata;
          end
          if (done_s) begin
            state_r <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (check_pass_s) begin
            key_out_r   <= shadow_s;
            key_valid_r <= 1'b1;
            fail_cnt_r  <= '0;
            state_r     <= ST_ARMED;
          end else begin
            fail_r     <= 1'b1;
            fail_cnt_r <= fail_cnt_inc_s;
            if (fail_cnt_inc_s == FC_W'(MAX_FAIL)) begin
              lockout_r <= 1'b1;
              state_r   <= ST_LOCKOUT;
            end else begin
              state_r   <= ST_IDLE;
            end
          end
        end
        ST_LOCKOUT: begin
          key_out_r   <= '0;
          key_valid_r <= 1'b0;
          lockout_r   <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          key_out_r   <= '0;
          key_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign key_sready = (state_r == ST_LOAD);
  assign busy       = (state_r == ST_LOAD) || (state_r == ST_CHECK);
  assign key_out    = key_out_r;
  assign key_valid  = key_valid_r;
  assign fail       = fail_r;
  assign lockout    = lockout_r;
  assign fail_cnt   = fail_cnt_r;

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed self-checking bench for lock_key_loader.
module tb_lock_key_loader;

  localparam int KEY_W    = 12;
  localparam int MAX_FAIL = 3;
`ifdef KEY_PARITY_CHK_EN
  localparam int L = KEY_W + 1;
`else
  localparam int L = KEY_W;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             key_sdata = 1'b0;
  logic             key_svalid = 1'b0;
  logic             key_sready;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             busy;
  logic             fail;
  logic             lockout;
  logic [1:0]       fail_cnt;

  int checks = 0;
  int failures = 0;

  lock_key_loader #(.KEY_W(KEY_W), .MAX_FAIL(MAX_FAIL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_sdata  (key_sdata),
    .key_svalid (key_svalid),
    .key_sready (key_sready),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .busy       (busy),
    .fail       (fail),
    .lockout    (lockout),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " key_out"},   32'(key_out),    32'd0);
    chk({tag, " key_valid"}, 32'(key_valid),  32'd0);
    chk({tag, " busy"},      32'(busy),       32'd0);
    chk({tag, " sready"},    32'(key_sready), 32'd0);
    chk({tag, " fail"},      32'(fail),       32'd0);
    chk({tag, " lockout"},   32'(lockout),    32'd0);
    chk({tag, " fail_cnt"},  32'(fail_cnt),   32'd0);
  endtask

  // Issue start, stream L bits (with an optional stall after stall_after bits,
  // during which start is also held high and must be ignored), step through
  // CHECK, and return #1 after the commit edge.
  task automatic run_load(input logic [KEY_W-1:0] key, input logic pbit,
                          input int stall_after, input int stall_len);
    int bi;
    int stalled;
    bi = 0;
    stalled = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (bi < L) begin
      chk("load busy",      32'(busy),       32'd1);
      chk("load sready",    32'(key_sready), 32'd1);
      chk("load key_valid", 32'(key_valid),  32'd0);
      chk("load key_out",   32'(key_out),    32'd0);
      chk("load fail",      32'(fail),       32'd0);
      if (bi == stall_after && stalled < stall_len) begin
        key_svalid = 1'b0;
        start = 1'b1;
        stalled++;
      end else begin
        start = 1'b0;
        key_svalid = 1'b1;
        if (bi < KEY_W) key_sdata = key[bi];
        else            key_sdata = pbit;
        bi++;
      end
      @(posedge clk); #1;
    end
    key_svalid = 1'b0;
    key_sdata = 1'b0;
    chk("check busy",      32'(busy),       32'd1);
    chk("check sready",    32'(key_sready), 32'd0);
    chk("check key_valid", 32'(key_valid),  32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("idle");

    // Gap-free load of 0xA5C
    run_load(12'hA5C, 1'b0, -1, 0);
    chk("t1 key_valid", 32'(key_valid), 32'd1);
    chk("t1 key_out",   32'(key_out),   32'hA5C);
    chk("t1 busy",      32'(busy),      32'd0);
    chk("t1 fail",      32'(fail),      32'd0);
    @(posedge clk); #1;
    chk("t1 stable",    32'(key_out),   32'hA5C);

    // Same key with a 3-cycle stall mid-stream; start during stall ignored
    run_load(12'hA5C, 1'b0, 6, 3);
    start = 1'b0;
    chk("t2 key_valid", 32'(key_valid), 32'd1);
    chk("t2 key_out",   32'(key_out),   32'hA5C);

    // Reload from ARMED with 0x3F0
    run_load(12'h3F0, 1'b0, -1, 0);
    chk("t3 key_valid", 32'(key_valid), 32'd1);
    chk("t3 key_out",   32'(key_out),   32'h3F0);

    // Reset asserted after 6 bits of a load
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      key_svalid = 1'b1;
      key_sdata = 1'b1;
      @(posedge clk); #1;
    end
    key_svalid = 1'b0;
    chk("t4 mid busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("t4 rst");
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_load(12'h001, 1'b0, -1, 0);
    chk("t4 key_valid", 32'(key_valid), 32'd1);
    chk("t4 key_out",   32'(key_out),   32'h001);

`ifdef KEY_PARITY_CHK_EN
    // Good parity (0xA5C has 6 ones, parity bit 0)
    run_load(12'hA5C, 1'b0, -1, 0);
    chk("p1 key_valid", 32'(key_valid), 32'd1);
    chk("p1 key_out",   32'(key_out),   32'hA5C);
    chk("p1 fail_cnt",  32'(fail_cnt),  32'd0);
    // Bad parity loads escalate to lockout
    run_load(12'hA5C, 1'b1, -1, 0);
    chk("p2 fail",      32'(fail),      32'd1);
    chk("p2 key_out",   32'(key_out),   32'd0);
    chk("p2 key_valid", 32'(key_valid), 32'd0);
    chk("p2 busy",      32'(busy),      32'd0);
    chk("p2 fail_cnt",  32'(fail_cnt),  32'd1);
    chk("p2 lockout",   32'(lockout),   32'd0);
    run_load(12'hA5C, 1'b1, -1, 0);
    chk("p3 fail_cnt",  32'(fail_cnt),  32'd2);
    chk("p3 lockout",   32'(lockout),   32'd0);
    run_load(12'hA5C, 1'b1, -1, 0);
    chk("p4 fail_cnt",  32'(fail_cnt),  32'd3);
    chk("p4 lockout",   32'(lockout),   32'd1);
    chk("p4 fail",      32'(fail),      32'd1);
    // Start ignored in lockout
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("p5 sready",    32'(key_sready), 32'd0);
    chk("p5 busy",      32'(busy),       32'd0);
    chk("p5 lockout",   32'(lockout),    32'd1);
    chk("p5 key_out",   32'(key_out),    32'd0);
    @(posedge clk); #1;
    chk("p5 lockout2",  32'(lockout),    32'd1);
    // Only reset clears lockout
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("p6 rst");
    @(negedge clk); rst_n = 1'b1;
`else
    chk("np fail",     32'(fail),     32'd0);
    chk("np lockout",  32'(lockout),  32'd0);
    chk("np fail_cnt", 32'(fail_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
